line_steer: RTL and testbench

Line-sensor steering front end for the drive path. Synchronises and debounces the 5-bit IR line-sensor array, classifies the stable pattern and produces the 4-bit `dirControl` steering code consumed by the drive block. It also flags junctions and a lost line. The drive block is the receiver of this code; this block is its producer.

---
 rtl/line_steer_pkg.sv | 73 +++++++
 rtl/line_steer_sense_debounce.sv | 78 +++++++
 rtl/line_steer.sv | 151 +++++++++++++++
 tb/tb_line_steer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/line_steer_pkg.sv
// line_steer_pkg: steering codes, classifier types and helpers shared by the
// line-sensor front end. The action/severity codes are the same encoding the
// drive block decodes from dirControl.
package line_steer_pkg;

    // Action field, dirControl[3:2]
    localparam logic [1:0] ACT_PROCEED = 2'b00;
    localparam logic [1:0] ACT_LEFT    = 2'b01;
    localparam logic [1:0] ACT_RIGHT   = 2'b10;
    localparam logic [1:0] ACT_STOP    = 2'b11;

    // Severity field, dirControl[1:0]
    localparam logic [1:0] SEV_NONE = 2'b00;
    localparam logic [1:0] SEV_VEER = 2'b01;
    localparam logic [1:0] SEV_HARD = 2'b10;
    localparam logic [1:0] SEV_STOP = 2'b11;

    localparam logic [3:0] CODE_STOP = {ACT_STOP, SEV_NONE};

    // Travel direction
    localparam logic DIR_FORWARDS = 1'b0;
    localparam logic DIR_REVERSE  = 1'b1;

    typedef enum logic [1:0] {
        CLS_TRACK    = 2'd0,
        CLS_JUNCTION = 2'd1,
        CLS_LOST     = 2'd2,
        CLS_INVALID  = 2'd3
    } cls_kind_e;

    typedef struct packed {
        cls_kind_e  kind;
        logic [1:0] action;
        logic [1:0] severity;
    } cls_t;

    typedef enum logic [1:0] {
        ST_TRACK   = 2'd0,
        ST_LOST    = 2'd1,
        ST_STOPPED = 2'd2
    } state_e;

    // Reverse the sensor order so that "left" always means left of travel.
    function automatic logic [4:0] mirror5(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) begin
            r[i] = v[4-i];
        end
        return r;
    endfunction

    // Map a debounced pattern ([4] leftmost) to a class and steering code.
    function automatic cls_t classify(input logic [4:0] p);
        cls_t c;
        c.kind     = CLS_TRACK;
        c.action   = ACT_PROCEED;
        c.severity = SEV_NONE;
        case (p)
            5'b00100, 5'b01110: ;
            5'b01100, 5'b01000: begin c.action = ACT_LEFT;  c.severity = SEV_VEER; end
            5'b11000, 5'b10000: begin c.action = ACT_LEFT;  c.severity = SEV_HARD; end
            5'b11100, 5'b11110: begin c.action = ACT_LEFT;  c.severity = SEV_STOP; end
            5'b00110, 5'b00010: begin c.action = ACT_RIGHT; c.severity = SEV_VEER; end
            5'b00011, 5'b00001: begin c.action = ACT_RIGHT; c.severity = SEV_HARD; end
            5'b00111, 5'b01111: begin c.action = ACT_RIGHT; c.severity = SEV_STOP; end
            5'b11111:           c.kind = CLS_JUNCTION;
            5'b00000:           c.kind = CLS_LOST;
            default:            c.kind = CLS_INVALID;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/line_steer_sense_debounce.sv
// sense_debounce: input conditioning for the line sensors.
//   clk, rst      : system clock, synchronous active-high reset
//   lineSense[4:0]: raw sensors, asynchronous to clk
//   direction     : 1 = reverse, mirrors the synchronised pattern
//   tick          : one-clock pulse on the sample divider terminal count
//   lineStable    : pattern accepted after DEBOUNCE_N identical samples
module sense_debounce
    import line_steer_pkg::*;
#(
    parameter int SAMPLE_DIV = 100_000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] lineSense,
    input  logic       direction,
    output logic       tick,
    output logic [4:0] lineStable
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_N + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_N);

    logic [4:0]       sync1_q, sync1_d;
    logic [4:0]       sync2_q, sync2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       stable_q, stable_d;
    logic [4:0]       sample;

    always_comb begin
        sync1_d  = lineSense;
        sync2_d  = sync1_q;
        // Mirroring sits after the synchroniser so a direction change is
        // seen as an ordinary pattern change and re-debounced.
        sample   = (direction == DIR_REVERSE) ? mirror5(sync2_q) : sync2_q;
        tick     = (div_q == DIV_LAST);
        div_d    = tick ? '0 : div_q + 1'b1;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (tick) begin
            if (sample != cand_q) begin
                cand_d = sample;
                cnt_d  = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == CNT_MAX) begin
                stable_d = cand_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            div_q    <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            div_q    <= div_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign lineStable = stable_q;

endmodule

// File: rtl/line_steer.sv
// line_steer: line-sensor steering front end feeding the drive block.
//   clk, rst        : system clock, synchronous active-high reset
//   lineSense[4:0]  : raw IR sensors, [4] leftmost, 1 = line seen
//   direction       : 0 forwards, 1 reverse (mirrors sensor order)
//   dirControl[3:0] : {action, severity} steering code
//   junction        : one-clock pulse when a junction stops the vehicle
//   lostLine        : high while stopped after a lost-line timeout
//   lineStable[4:0] : debounced pattern, for LEDs
module line_steer
    import line_steer_pkg::*;
#(
    parameter int SAMPLE_DIV   = 100_000,
    parameter int DEBOUNCE_N   = 4,
    parameter int LOST_TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] lineSense,
    input  logic       direction,
    output logic [3:0] dirControl,
    output logic       junction,
    output logic       lostLine,
    output logic [4:0] lineStable
);

    localparam int LC_W = $clog2(LOST_TIMEOUT + 1);
    localparam logic [LC_W-1:0] LOST_MAX = LC_W'(LOST_TIMEOUT);

    logic       tick;
    logic [4:0] stable;
    cls_t       cls;
    logic [3:0] track_code;

    state_e          state_q, state_d;
    logic [3:0]      dir_q, dir_d;
    logic            junction_q, junction_d;
    logic            lost_line_q, lost_line_d;
    logic [1:0]      last_side_q, last_side_d;
    logic [LC_W-1:0] lost_cnt_q, lost_cnt_d;

    sense_debounce #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .DEBOUNCE_N (DEBOUNCE_N)
    ) u_sense (
        .clk        (clk),
        .rst        (rst),
        .lineSense  (lineSense),
        .direction  (direction),
        .tick       (tick),
        .lineStable (stable)
    );

    always_comb begin
        cls         = classify(stable);
        track_code  = {cls.action, cls.severity};
        state_d     = state_q;
        dir_d       = dir_q;
        junction_d  = 1'b0;
        lost_line_d = lost_line_q;
        last_side_d = last_side_q;
        lost_cnt_d  = lost_cnt_q;

        // A tracking class always reports its code; only a real turn
        // remembers the side we last saw the line on.
        if (cls.kind == CLS_TRACK && cls.action != ACT_PROCEED) begin
            last_side_d = cls.action;
        end

        unique case (state_q)
            ST_TRACK: begin
                case (cls.kind)
                    CLS_TRACK: dir_d = track_code;
                    CLS_JUNCTION: begin
                        state_d    = ST_STOPPED;
                        dir_d      = CODE_STOP;
                        junction_d = 1'b1;
                    end
                    CLS_LOST: begin
                        state_d    = ST_LOST;
                        lost_cnt_d = '0;
                        dir_d      = {last_side_q, SEV_HARD};
                    end
                    default: ;  // invalid: hold previous output
                endcase
            end
            ST_LOST: begin
                case (cls.kind)
                    CLS_TRACK: begin
                        state_d = ST_TRACK;
                        dir_d   = track_code;
                    end
                    CLS_JUNCTION: begin
                        state_d    = ST_STOPPED;
                        dir_d      = CODE_STOP;
                        junction_d = 1'b1;
                    end
                    CLS_LOST: begin
                        dir_d = {last_side_q, SEV_HARD};
                        if (tick) begin
                            if (lost_cnt_q != LOST_MAX) begin
                                lost_cnt_d = lost_cnt_q + 1'b1;
                            end
                            if (lost_cnt_d == LOST_MAX) begin
                                state_d     = ST_STOPPED;
                                dir_d       = CODE_STOP;
                                lost_line_d = 1'b1;
                            end
                        end
                    end
                    default: ;  // invalid: keep searching, timer paused
                endcase
            end
            ST_STOPPED: begin
                dir_d = CODE_STOP;
                if (cls.kind == CLS_TRACK) begin
                    state_d     = ST_TRACK;
                    dir_d       = track_code;
                    lost_line_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_STOPPED;
                dir_d   = CODE_STOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_STOPPED;
            dir_q       <= CODE_STOP;
            junction_q  <= 1'b0;
            lost_line_q <= 1'b0;
            last_side_q <= ACT_LEFT;
            lost_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            junction_q  <= junction_d;
            lost_line_q <= lost_line_d;
            last_side_q <= last_side_d;
            lost_cnt_q  <= lost_cnt_d;
        end
    end

    assign dirControl = dir_q;
    assign junction   = junction_q;
    assign lostLine   = lost_line_q;
    assign lineStable = stable;

endmodule

// File: tb/tb_line_steer.sv
// tb_line_steer: directed vectors for line_steer with small timing parameters.
// The bench tracks the sample-divider phase itself (it restarts at reset) so
// each check lands on a known tick boundary.
module tb_line_steer;

    localparam int SD = 4;
    localparam int DN = 3;
    localparam int LT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] lineSense = 5'b0;
    logic       direction = 1'b0;
    logic [3:0] dirControl;
    logic       junction;
    logic       lostLine;
    logic [4:0] lineStable;

    int nchk  = 0;
    int nerr  = 0;
    int phase = 0;
    int jcnt  = 0;
    int j0    = 0;

    always #5 clk = ~clk;

    // Clocks with junction high, sampled just before each edge.
    always @(posedge clk) if (junction === 1'b1) jcnt <= jcnt + 1;

    line_steer #(
        .SAMPLE_DIV   (SD),
        .DEBOUNCE_N   (DN),
        .LOST_TIMEOUT (LT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lineSense  (lineSense),
        .direction  (direction),
        .dirControl (dirControl),
        .junction   (junction),
        .lostLine   (lostLine),
        .lineStable (lineStable)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance n clocks; returns at the following negedge.
    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk);
            phase = (phase + 1) % SD;
            @(negedge clk);
        end
    endtask

    // Advance through n sample ticks; returns just after the tick edge.
    task automatic ticks(input int n);
        repeat (n) begin
            clk_n(1);
            while (phase != 0) clk_n(1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clk_n(2);
        rst = 1'b0;
        phase = 0;
    endtask

    // Apply a pattern, check acceptance on the 3rd tick and the code one
    // clock later.
    task automatic accept(input string tag, input logic [4:0] pat,
                          input logic [4:0] stab, input logic [3:0] prev,
                          input logic [3:0] code);
        lineSense = pat;
        ticks(2);
        chk({tag, "_early"}, 8'(lineStable === stab && pat != 5'b0 ? 1 : 0), 8'(0));
        ticks(1);
        chk({tag, "_stable"}, 8'(lineStable), 8'(stab));
        chk({tag, "_hold"}, 8'(dirControl), 8'(prev));
        clk_n(1);
        chk({tag, "_dir"}, 8'(dirControl), 8'(code));
    endtask

    initial begin
        do_reset();
        chk("rst_dir",    8'(dirControl), 8'hC);
        chk("rst_junc",   8'(junction),   8'h0);
        chk("rst_lost",   8'(lostLine),   8'h0);
        chk("rst_stable", 8'(lineStable), 8'h00);

        // First acceptance straight out of reset.
        accept("fwd0", 5'b00100, 5'b00100, 4'b1100, 4'b0000);
        accept("left", 5'b01000, 5'b01000, 4'b0000, 4'b0101);
        accept("hrgt", 5'b00011, 5'b00011, 4'b0101, 4'b1010);
        accept("slft", 5'b11100, 5'b11100, 4'b1010, 4'b0111);
        accept("fwd1", 5'b00100, 5'b00100, 4'b0111, 4'b0000);

        // Two-tick glitch must never reach lineStable.
        lineSense = 5'b10000;
        ticks(2);
        chk("glitch_mid", 8'(lineStable), 8'(5'b00100));
        lineSense = 5'b00100;
        ticks(3);
        clk_n(1);
        chk("glitch_stable", 8'(lineStable), 8'(5'b00100));
        chk("glitch_dir",    8'(dirControl), 8'h0);

        // Invalid pattern is accepted but holds the previous code.
        accept("inval", 5'b10101, 5'b10101, 4'b0000, 4'b0000);

        // Junction: stop with a single-clock pulse.
        j0 = jcnt;
        lineSense = 5'b11111;
        ticks(3);
        chk("junc_stable", 8'(lineStable), 8'h1F);
        chk("junc_pre",    8'(junction),   8'h0);
        clk_n(1);
        chk("junc_dir",    8'(dirControl), 8'hC);
        chk("junc_pulse",  8'(junction),   8'h1);
        clk_n(1);
        chk("junc_drop",   8'(junction),   8'h0);
        clk_n(6);
        chk("junc_width",  8'(jcnt - j0),  8'h1);
        accept("jexit", 5'b00100, 5'b00100, 4'b1100, 4'b0000);

        // Lost line after a right veer, then timeout.
        accept("rveer", 5'b00010, 5'b00010, 4'b0000, 4'b1001);
        j0 = jcnt;
        lineSense = 5'b00000;
        ticks(3);
        clk_n(1);
        chk("lost_dir",   8'(dirControl), 8'hA);
        chk("lost_lvl0",  8'(lostLine),   8'h0);
        ticks(4);
        clk_n(1);
        chk("lost_dir4",  8'(dirControl), 8'hA);
        chk("lost_lvl4",  8'(lostLine),   8'h0);
        ticks(1);
        clk_n(1);
        chk("lost_stop",  8'(dirControl), 8'hC);
        chk("lost_lvl5",  8'(lostLine),   8'h1);
        chk("lost_njunc", 8'(jcnt - j0),  8'h0);
        accept("lexit", 5'b00100, 5'b00100, 4'b1100, 4'b0000);
        chk("lexit_lvl",  8'(lostLine),   8'h0);

        // Reverse mirrors 01000 into a right veer.
        direction = 1'b1;
        accept("rev", 5'b01000, 5'b00010, 4'b0000, 4'b1001);

        // Reset in the middle of a debounce.
        lineSense = 5'b00100;
        ticks(2);
        do_reset();
        chk("rst2_dir",    8'(dirControl), 8'hC);
        chk("rst2_junc",   8'(junction),   8'h0);
        chk("rst2_lost",   8'(lostLine),   8'h0);
        chk("rst2_stable", 8'(lineStable), 8'h00);
        ticks(2);
        chk("rst2_early",  8'(lineStable), 8'h00);
        ticks(1);
        chk("rst2_acc",    8'(lineStable), 8'(5'b00100));
        clk_n(1);
        chk("rst2_dir2",   8'(dirControl), 8'h0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
